hdc_core_ctrl: RTL and testbench
================================

Name: hdc_core_ctrl

Overview:
- Sequencer for one HDC core (item memory plus reg_0/1/2 datapath).
- On `start` it performs two phases:
  - Optional GEN phase: fills item memory with pseudo-random hypervectors built from an internal xorshift32.
  - EXEC phase: streams 16-bit instructions from a valid/ready source into the core, with correct get_v/exec alignment.
- After the core reports `last`, it drops `run` (clearing core registers) and pulses `done`.
- Sits between the host/DMA instruction FIFO and the core.

Parameters:
- DIM, 1023, MSB index of a hypervector (vector width DIM+1); DIM+1 must be a multiple of 32.
- ITEMS, 1024, item memory depth; item address width is fixed at 10 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start pulse; ignored unless IDLE
- gen_en  in  1  sampled at start; 1 = run GEN phase before EXEC
- item_num  in  11  sampled at start; number of items to generate (0..1024)
- seed  in  32  sampled at start; xorshift seed (0 is replaced by 32'h1)
- inst_valid  in  1  instruction available
- inst_data  in  16  instruction word
- inst_ready  out  1  controller accepts inst_data this cycle
- core_last  in  1  core `last` output
- core_store  in  1  core `store` output
- run  out  1  core run
- gen  out  1  core gen
- update_item  out  1  core update_item
- item_a  out  10  core item address
- rand_num  out  DIM+1  core random vector
- get_v  out  1  core instruction valid
- get_d  out  16  core instruction
- exec  out  1  core exec
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- store_cnt  out  16  number of core_store cycles in the current run; held until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; every output is 0, including rand_num, store_cnt and the xorshift state.
- States: IDLE, GEN_FILL, GEN_WRITE, EXEC, DRAIN, FINISH.
- IDLE:
  - start=1: latch item_num/seed, clear store_cnt, set run=1.
  - If gen_en=1 and item_num!=0, go to GEN_FILL. Otherwise go to EXEC.
- GEN_FILL:
  - gen=1 throughout GEN_FILL and GEN_WRITE.
  - Each cycle, xorshift32 advances (x^=x<<13; x^=x>>17; x^=x<<5). rand_num shifts left by 32 and takes the new x in bits [31:0].
  - After WORDS=(DIM+1)/32 cycles, go to GEN_WRITE.
- GEN_WRITE:
  - Exactly one cycle with update_item=1 and item_a=item counter.
  - Counter increments. If counter==item_num-1, go to EXEC; otherwise go back to GEN_FILL.
  - get_v is guaranteed 0 throughout GEN, so the core never sees a writeback collision.
- EXEC:
  - inst_ready=1.
  - Handshake (inst_valid&inst_ready) registers get_v<=1 and get_d<=inst_data. With no handshake, get_v<=0 and get_d holds.
  - exec is get_v delayed one cycle. An instruction accepted at edge N gives get_v high in cycle N..N+1 and exec high in cycle N+1..N+2, matching the core's registered inst/reg_tmp.
  - Gaps in inst_valid produce get_v=0, which the core executes as nop.
  - Accepting a last opcode (bit15=0, bits14:11=0, bit10=1) goes to DRAIN with inst_ready=0 from the next cycle.
- DRAIN:
  - inst_ready=0; get_v=0 after the last opcode's cycle; exec follows its delayed pipeline.
  - Wait for core_last=1, then go to FINISH.
  - There is no timeout.
- FINISH (one cycle): run=0, done=1, then go to IDLE.
- store_cnt increments on every cycle with core_store=1 while busy, saturating at 16'hFFFF.
- Simultaneous start and rst_n=0: reset wins.
- Reset mid-GEN or mid-EXEC: immediate IDLE with all outputs 0. Partially written item memory is not cleaned.
- item_num>1024 is treated as 1024. item_a wraps never, since the count is bounded.

Decomposition:
- Package hdc_ctrl_pkg holds:
  - state enum ctrl_state_t;
  - opcode field constants (OP_ADDR_BIT=15, OP_LAST_BIT=10, etc.);
  - XS_DEFAULT_SEED=32'h1;
  - function is_last_op().
- Sub-module hdc_xorshift32 (advance-enable, seed load, 32-bit out) is natural. The rest is a single FSM.

Test Plan:
- DIM=63, gen_en=1, item_num=3, seed=1 -> three update_item pulses with item_a=0,1,2, each after 2 fill cycles; item 0 rand_num={32'h00042021,32'h04080601} (upper word is the 1st xorshift value); exec then starts, busy=1.
- gen_en=0, stream {load 5, xor 7, store, last} with inst_valid constant -> get_v 4 consecutive cycles, exec the same 4 cycles delayed by 1; core_store=1 once gives store_cnt=1; core_last gives run=0 and done=1 for one cycle.
- Same stream with inst_valid low every other cycle -> get_v/exec show the matching gaps; no instruction dropped or duplicated; inst_ready=0 after last is accepted.
- gen_en=1, item_num=0 -> no gen/update_item assertion; EXEC entered the cycle after start.
- rst_n pulsed low during GEN_FILL of item 1 -> all outputs 0 asynchronously; next start with seed=0 behaves as seed=1.
- start pulsed while busy -> ignored; latched item_num and seed unchanged; store_cnt not cleared.

Source files
------------

// File: rtl/hdc_ctrl_pkg.sv
// Shared definitions for the HDC core sequencer: FSM states, instruction
// field positions and the xorshift seed fallback.
package hdc_ctrl_pkg;

    localparam logic [2:0] ST_IDLE_C      = 3'd0;
    localparam logic [2:0] ST_GEN_FILL_C  = 3'd1;
    localparam logic [2:0] ST_GEN_WRITE_C = 3'd2;
    localparam logic [2:0] ST_EXEC_C      = 3'd3;
    localparam logic [2:0] ST_DRAIN_C     = 3'd4;
    localparam logic [2:0] ST_FINISH_C    = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = ST_IDLE_C,
        ST_GEN_FILL  = ST_GEN_FILL_C,
        ST_GEN_WRITE = ST_GEN_WRITE_C,
        ST_EXEC      = ST_EXEC_C,
        ST_DRAIN     = ST_DRAIN_C,
        ST_FINISH    = ST_FINISH_C
    } ctrl_state_t;

    localparam int OP_ADDR_BIT = 15;
    localparam int OP_CODE_HI  = 14;
    localparam int OP_CODE_LO  = 11;
    localparam int OP_LAST_BIT = 10;

    localparam logic [31:0] XS_DEFAULT_SEED = 32'h1;

    // A last opcode is a non-address instruction with a zero opcode field and the last flag set.
    function automatic logic is_last_op(input logic [15:0] op);
        return !op[OP_ADDR_BIT] && (op[OP_CODE_HI:OP_CODE_LO] == 4'd0) && op[OP_LAST_BIT];
    endfunction

endpackage

// File: rtl/hdc_xorshift32.sv
// xorshift32 generator; rnd_next is the value the state advances to, so the
// caller can capture the fresh word on the same edge it advances.
module hdc_xorshift32
    import hdc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] rnd_next
);

    logic [31:0] x_reg;
    logic [31:0] s1;
    logic [31:0] s2;

    always_comb begin
        s1       = x_reg ^ (x_reg << 13);
        s2       = s1 ^ (s1 >> 17);
        rnd_next = s2 ^ (s2 << 5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg <= '0;
        end else if (load) begin
            x_reg <= (seed == 32'd0) ? XS_DEFAULT_SEED : seed;
        end else if (advance) begin
            x_reg <= rnd_next;
        end
    end

endmodule

// File: rtl/hdc_core_ctrl.sv
// Sequencer for one HDC core: optional item-memory fill with random
// hypervectors, then instruction streaming until the core reports last.
module hdc_core_ctrl
    import hdc_ctrl_pkg::*;
#(
    parameter int DIM   = 1023,
    parameter int ITEMS = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         gen_en,
    input  logic [10:0]  item_num,
    input  logic [31:0]  seed,
    input  logic         inst_valid,
    input  logic [15:0]  inst_data,
    output logic         inst_ready,
    input  logic         core_last,
    input  logic         core_store,
    output logic         run,
    output logic         gen,
    output logic         update_item,
    output logic [9:0]   item_a,
    output logic [DIM:0] rand_num,
    output logic         get_v,
    output logic [15:0]  get_d,
    output logic         exec,
    output logic         busy,
    output logic         done,
    output logic [15:0]  store_cnt
);

    localparam int WORDS = (DIM + 1) / 32;
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [10:0] ITEM_MAX = 11'(ITEMS);

    ctrl_state_t    state_reg;
    logic [WCW-1:0] word_cnt_reg;
    logic [9:0]     item_cnt_reg;
    logic [10:0]    item_num_reg;
    logic [DIM:0]   rand_reg;
    logic [DIM:0]   rand_next;
    logic           get_v_reg;
    logic [15:0]    get_d_reg;
    logic           exec_reg;
    logic [15:0]    store_cnt_reg;
    logic [31:0]    rnd_next;
    logic           start_ok;
    logic           fill;
    logic           handshake;
    logic           last_item;

    assign start_ok  = (state_reg == ST_IDLE) && start;
    assign fill      = (state_reg == ST_GEN_FILL);
    assign handshake = (state_reg == ST_EXEC) && inst_valid;
    assign last_item = ({1'b0, item_cnt_reg} == (item_num_reg - 11'd1));

    hdc_xorshift32 u_xorshift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start_ok),
        .advance  (fill),
        .seed     (seed),
        .rnd_next (rnd_next)
    );

    // Word-wise shift: the oldest xorshift word ends up in the top slice.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            if (gi == 0) begin : g_head
                assign rand_next[31:0] = rnd_next;
            end else begin : g_tail
                assign rand_next[gi*32 +: 32] = rand_reg[(gi-1)*32 +: 32];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rand_reg <= '0;
        end else if (fill) begin
            rand_reg <= rand_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            item_cnt_reg <= '0;
            item_num_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        item_num_reg <= (item_num > ITEM_MAX) ? ITEM_MAX : item_num;
                        item_cnt_reg <= '0;
                        word_cnt_reg <= '0;
                        state_reg    <= (gen_en && item_num != 11'd0) ? ST_GEN_FILL : ST_EXEC;
                    end
                end
                ST_GEN_FILL: begin
                    if (word_cnt_reg == WCW'(WORDS - 1)) begin
                        word_cnt_reg <= '0;
                        state_reg    <= ST_GEN_WRITE;
                    end else begin
                        word_cnt_reg <= word_cnt_reg + 1'b1;
                    end
                end
                ST_GEN_WRITE: begin
                    // Counter stops on the final item so item_a never wraps past the last address.
                    if (last_item) begin
                        state_reg <= ST_EXEC;
                    end else begin
                        item_cnt_reg <= item_cnt_reg + 1'b1;
                        state_reg    <= ST_GEN_FILL;
                    end
                end
                ST_EXEC: begin
                    if (inst_valid && is_last_op(inst_data)) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (core_last) begin
                        state_reg <= ST_FINISH;
                    end
                end
                ST_FINISH: state_reg <= ST_IDLE;
                default:   state_reg <= ST_IDLE;
            endcase
        end
    end

    // get_v/get_d line up with the core's registered instruction; exec trails by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            get_v_reg <= 1'b0;
            get_d_reg <= '0;
            exec_reg  <= 1'b0;
        end else begin
            get_v_reg <= handshake;
            if (handshake) begin
                get_d_reg <= inst_data;
            end
            exec_reg <= get_v_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_cnt_reg <= '0;
        end else if (start_ok) begin
            store_cnt_reg <= '0;
        end else if (busy && core_store && store_cnt_reg != 16'hFFFF) begin
            store_cnt_reg <= store_cnt_reg + 16'd1;
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign run         = busy && (state_reg != ST_FINISH);
    assign gen         = (state_reg == ST_GEN_FILL) || (state_reg == ST_GEN_WRITE);
    assign update_item = (state_reg == ST_GEN_WRITE);
    assign item_a      = item_cnt_reg;
    assign rand_num    = rand_reg;
    assign inst_ready  = (state_reg == ST_EXEC);
    assign get_v       = get_v_reg;
    assign get_d       = get_d_reg;
    assign exec        = exec_reg;
    assign done        = (state_reg == ST_FINISH);
    assign store_cnt   = store_cnt_reg;

endmodule

// File: tb/tb_hdc_core_ctrl.sv
// Directed bench for hdc_core_ctrl with a 64-bit hypervector (two xorshift words per item).
`timescale 1ns/1ps
module tb_hdc_core_ctrl;

    localparam int DIM = 63;
    localparam logic [63:0] XS_SEED1_W01 = 64'h00042021_04080601;
    localparam logic [63:0] XS_SEED1_W23 = 64'h9DCCA8C5_1255994F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         gen_en = 1'b0;
    logic [10:0]  item_num = '0;
    logic [31:0]  seed = '0;
    logic         inst_valid = 1'b0;
    logic [15:0]  inst_data = '0;
    logic         inst_ready;
    logic         core_last = 1'b0;
    logic         core_store = 1'b0;
    logic         run;
    logic         gen;
    logic         update_item;
    logic [9:0]   item_a;
    logic [DIM:0] rand_num;
    logic         get_v;
    logic [15:0]  get_d;
    logic         exec;
    logic         busy;
    logic         done;
    logic [15:0]  store_cnt;

    int total = 0;
    int bad = 0;

    logic [15:0] prog [4] = '{16'h8005, 16'h1007, 16'h1800, 16'h0400};
    bit          tr_gv  [32];
    bit          tr_ex  [32];
    bit          tr_rdy [32];
    bit          tr_dn  [32];
    bit          tr_run [32];
    logic [15:0] tr_gd  [32];

    always #5 clk = ~clk;

    hdc_core_ctrl #(.DIM(DIM), .ITEMS(1024)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .gen_en      (gen_en),
        .item_num    (item_num),
        .seed        (seed),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_ready  (inst_ready),
        .core_last   (core_last),
        .core_store  (core_store),
        .run         (run),
        .gen         (gen),
        .update_item (update_item),
        .item_a      (item_a),
        .rand_num    (rand_num),
        .get_v       (get_v),
        .get_d       (get_d),
        .exec        (exec),
        .busy        (busy),
        .done        (done),
        .store_cnt   (store_cnt)
    );

    // Sends the last opcode from EXEC, then holds core_last until done is seen.
    task automatic finish_exec(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        inst_valid = 1'b1;
        inst_data  = 16'h0400;
        @(negedge clk);
        inst_valid = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            core_last = 1'b1;
            if (done) ok = 1'b1;
        end
        core_last = 1'b0;
        @(negedge clk);
    endtask

    // Streams prog with gen_en=0, recording outputs per sample s (s1 = first negedge after start).
    task automatic run_stream(input bit gaps, output bit ok);
        int idx;
        bit last_sent;
        idx = 0;
        last_sent = 1'b0;
        ok = 1'b0;
        @(negedge clk);
        gen_en = 1'b0; item_num = '0; seed = 32'd0; start = 1'b1;
        for (int s = 1; s < 32; s++) begin
            @(negedge clk);
            start = 1'b0; core_store = 1'b0; core_last = 1'b0; inst_valid = 1'b0;
            tr_gv[s] = get_v; tr_ex[s] = exec; tr_gd[s] = get_d;
            tr_rdy[s] = inst_ready; tr_dn[s] = done; tr_run[s] = run;
            if (s == 3) core_store = 1'b1;
            if (idx < 4 && inst_ready && (!gaps || s[0])) begin
                inst_valid = 1'b1;
                inst_data  = prog[idx];
                idx++;
            end
            if (idx == 4 && !inst_ready && !get_v && !exec && !last_sent) begin
                core_last = 1'b1;
                last_sent = 1'b1;
            end
            if (done) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; gen_en = 1'b1; item_num = 11'd3; seed = 32'd1;
        repeat (2) @(negedge clk);
        total++;
        if ({run, gen, update_item, item_a, get_v, get_d, exec, busy, done, store_cnt, inst_ready} !== '0 || rand_num !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b run=%b gen=%b store_cnt=%h rand=%h exp all zero", busy, run, gen, store_cnt, rand_num);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || inst_ready !== 1'b0 || store_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_release got busy=%b ready=%b store_cnt=%h exp 0 0 0", busy, inst_ready, store_cnt);
        end
    endtask

    task automatic test_gen();
        int n;
        int first_exec;
        bit gv_seen;
        bit ok;
        n = 0; first_exec = 0; gv_seen = 1'b0;
        @(negedge clk);
        gen_en = 1'b1; item_num = 11'd3; seed = 32'd1; start = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (get_v) gv_seen = 1'b1;
            if (update_item) begin
                total++;
                if (item_a !== 10'(n) || s != 3 * (n + 1) || gen !== 1'b1) begin
                    bad++;
                    $display("FAIL gen_pulse%0d got item_a=%0d cycle=%0d gen=%b exp item_a=%0d cycle=%0d gen=1", n, item_a, s, gen, n, 3 * (n + 1));
                end
                if (n == 0) begin
                    total++;
                    if (rand_num !== XS_SEED1_W01) begin
                        bad++;
                        $display("FAIL gen_rand0 got %h exp %h", rand_num, XS_SEED1_W01);
                    end
                end
                n++;
            end
            if (inst_ready && first_exec == 0) begin
                first_exec = s;
                total++;
                if (busy !== 1'b1 || gen !== 1'b0) begin
                    bad++;
                    $display("FAIL gen_exec_state got busy=%b gen=%b exp 1 0", busy, gen);
                end
            end
        end
        total++;
        if (n != 3 || first_exec != 10 || gv_seen) begin
            bad++;
            $display("FAIL gen_summary got pulses=%0d exec_cycle=%0d get_v_seen=%b exp 3 10 0", n, first_exec, gv_seen);
        end
        finish_exec(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL gen_finish got done=0 exp done within 20 cycles");
        end
    endtask

    task automatic test_exec_stream();
        bit ok;
        logic [7:0] gv_vec;
        logic [7:0] ex_vec;
        logic [7:0] exp_gv;
        logic [7:0] exp_ex;
        exp_gv = 8'b0011_1100;
        exp_ex = 8'b0111_1000;
        run_stream(1'b0, ok);
        gv_vec = '0; ex_vec = '0;
        for (int s = 1; s < 8; s++) begin
            gv_vec[s] = tr_gv[s];
            ex_vec[s] = tr_ex[s];
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stream_done got no done exp done pulse");
        end
        total++;
        if (gv_vec !== exp_gv || ex_vec !== exp_ex) begin
            bad++;
            $display("FAIL stream_valid got get_v=%b exec=%b exp %b %b", gv_vec, ex_vec, exp_gv, exp_ex);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (tr_gd[k + 2] !== prog[k]) begin
                bad++;
                $display("FAIL stream_get_d%0d got %h exp %h", k, tr_gd[k + 2], prog[k]);
            end
        end
        total++;
        if (tr_rdy[4] !== 1'b1 || tr_rdy[5] !== 1'b0) begin
            bad++;
            $display("FAIL stream_ready got s4=%b s5=%b exp 1 0", tr_rdy[4], tr_rdy[5]);
        end
        total++;
        if (tr_dn[7] !== 1'b0 || tr_dn[8] !== 1'b1 || tr_dn[9] !== 1'b0 || tr_run[8] !== 1'b0 || tr_run[7] !== 1'b1) begin
            bad++;
            $display("FAIL stream_finish got done=%b%b%b run7=%b run8=%b exp 010 1 0", tr_dn[7], tr_dn[8], tr_dn[9], tr_run[7], tr_run[8]);
        end
        total++;
        if (store_cnt !== 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stream_store got store_cnt=%0d busy=%b exp 1 0", store_cnt, busy);
        end
    endtask

    task automatic test_exec_gaps();
        bit ok;
        int k;
        logic [15:0] gv_vec;
        logic [15:0] ex_vec;
        logic [15:0] exp_gv;
        logic [15:0] exp_ex;
        exp_gv = 16'h0154;
        exp_ex = 16'h02A8;
        run_stream(1'b1, ok);
        gv_vec = '0; ex_vec = '0;
        for (int s = 1; s < 16; s++) begin
            gv_vec[s] = tr_gv[s];
            ex_vec[s] = tr_ex[s];
        end
        total++;
        if (!ok || gv_vec !== exp_gv || ex_vec !== exp_ex) begin
            bad++;
            $display("FAIL gaps_valid got done=%b get_v=%h exec=%h exp 1 %h %h", ok, gv_vec, ex_vec, exp_gv, exp_ex);
        end
        k = 0;
        for (int s = 1; s < 16; s++) begin
            if (tr_gv[s]) begin
                total++;
                if (k > 3 || tr_gd[s] !== prog[k & 3]) begin
                    bad++;
                    $display("FAIL gaps_get_d%0d got %h exp %h", k, tr_gd[s], prog[k & 3]);
                end
                k++;
            end
        end
        total++;
        if (k != 4 || tr_rdy[7] !== 1'b1 || tr_rdy[8] !== 1'b0 || tr_dn[11] !== 1'b1) begin
            bad++;
            $display("FAIL gaps_order got count=%0d ready7=%b ready8=%b done11=%b exp 4 1 0 1", k, tr_rdy[7], tr_rdy[8], tr_dn[11]);
        end
    endtask

    task automatic test_gen_zero();
        bit ok;
        @(negedge clk);
        gen_en = 1'b1; item_num = 11'd0; seed = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (inst_ready !== 1'b1 || gen !== 1'b0 || update_item !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL gen_zero got ready=%b gen=%b upd=%b busy=%b exp 1 0 0 1", inst_ready, gen, update_item, busy);
        end
        finish_exec(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL gen_zero_finish got done=0 exp done");
        end
    endtask

    task automatic test_reset_mid_gen();
        bit ok;
        int pulse_s;
        logic [63:0] pulse_rand;
        @(negedge clk);
        gen_en = 1'b1; item_num = 11'd3; seed = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (gen !== 1'b1 || update_item !== 1'b0 || item_a !== 10'd1) begin
            bad++;
            $display("FAIL midgen_pre got gen=%b upd=%b item_a=%0d exp 1 0 1", gen, update_item, item_a);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({run, gen, update_item, item_a, get_v, get_d, exec, busy, done, store_cnt, inst_ready} !== '0 || rand_num !== '0) begin
            bad++;
            $display("FAIL midgen_async_reset got busy=%b gen=%b item_a=%0d rand=%h exp all zero", busy, gen, item_a, rand_num);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        gen_en = 1'b1; item_num = 11'd1; seed = 32'd0; start = 1'b1;
        pulse_s = 0; pulse_rand = '0;
        for (int s = 1; s <= 4; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (update_item && pulse_s == 0) begin
                pulse_s = s;
                pulse_rand = rand_num;
            end
        end
        total++;
        if (pulse_s != 3 || pulse_rand !== XS_SEED1_W01 || inst_ready !== 1'b1) begin
            bad++;
            $display("FAIL seed_zero got cycle=%0d rand=%h ready=%b exp 3 %h 1", pulse_s, pulse_rand, inst_ready, XS_SEED1_W01);
        end
        finish_exec(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL seed_zero_finish got done=0 exp done");
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int n;
        int first_exec;
        logic [15:0] cnt_at_exec;
        n = 0; first_exec = 0; cnt_at_exec = '0;
        @(negedge clk);
        gen_en = 1'b1; item_num = 11'd2; seed = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; core_store = 1'b1;
        @(negedge clk);
        core_store = 1'b0;
        start = 1'b1; gen_en = 1'b0; item_num = 11'd5; seed = 32'd7;
        for (int s = 3; s <= 20; s++) begin
            @(negedge clk);
            start = 1'b0;
            if (update_item) begin
                if (n == 1) begin
                    total++;
                    if (rand_num !== XS_SEED1_W23 || s != 6) begin
                        bad++;
                        $display("FAIL busy_start_item1 got rand=%h cycle=%0d exp %h 6", rand_num, s, XS_SEED1_W23);
                    end
                end
                n++;
            end
            if (inst_ready && first_exec == 0) begin
                first_exec = s;
                cnt_at_exec = store_cnt;
            end
        end
        total++;
        if (n != 2 || first_exec != 7 || cnt_at_exec !== 16'd1) begin
            bad++;
            $display("FAIL busy_start got pulses=%0d exec_cycle=%0d store_cnt=%0d exp 2 7 1", n, first_exec, cnt_at_exec);
        end
        finish_exec(ok);
        total++;
        if (!ok || store_cnt !== 16'd1) begin
            bad++;
            $display("FAIL busy_start_finish got done_seen=%b store_cnt=%0d exp 1 1", ok, store_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_gen();
        test_exec_stream();
        test_exec_gaps();
        test_gen_zero();
        test_reset_mid_gen();
        test_start_while_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
